// File: rtl/hd44780_pkg.sv
// hd44780_pkg: shared constants for the HD44780 / PCF8574 I2C target.
// Contents: target FSM state codes, PCF8574 port bit indices, the default
// 7-bit address, function-set opcode nibbles and the E-strobe helper.
package hd44780_pkg;

  // Target FSM state codes
  typedef logic [2:0] tgt_state_t;
  localparam tgt_state_t ST_IDLE      = 3'd0;
  localparam tgt_state_t ST_ADDR      = 3'd1;
  localparam tgt_state_t ST_ADDR_ACK  = 3'd2;
  localparam tgt_state_t ST_WRITE     = 3'd3;
  localparam tgt_state_t ST_WRITE_ACK = 3'd4;
  localparam tgt_state_t ST_READ      = 3'd5;
  localparam tgt_state_t ST_READ_ACK  = 3'd6;
  localparam tgt_state_t ST_IGNORE    = 3'd7;

  // PCF8574 pin assignment on a typical LCD backpack
  localparam int PORT_RS    = 0;
  localparam int PORT_RW    = 1;
  localparam int PORT_E     = 2;
  localparam int PORT_BL    = 3;
  localparam int PORT_D_LSB = 4;

  localparam logic [6:0] DEFAULT_ADDR = 7'h27;

  // Upper nibble of the function-set command: DL=0 (4-bit) and DL=1 (8-bit)
  localparam logic [3:0] FSET_DL4 = 4'b0010;
  localparam logic [3:0] FSET_DL8 = 4'b0011;

  // A write strobe is E falling from 1 to 0 while RW selects write
  function automatic logic is_strobe(input logic prev_e, input logic [7:0] cur);
    return prev_e & ~cur[PORT_E] & ~cur[PORT_RW];
  endfunction

endpackage

// File: rtl/hd44780_i2c_target_if.sv
// hd44780_i2c_target_if: bus and LCD-event signals of the I2C LCD target.
//   scl_in, sda_in : raw I2C lines into the target
//   sda_out        : open-drain SDA drive (0 pulls low)
//   busy           : addressed transaction in progress
//   port/backlight : last expander byte and its BL bit
//   nibble_mode    : decoded HD44780 is in 4-bit mode
//   lcd_valid/lcd_rs/lcd_data : one-cycle completed command/data event
// Modport slave is the target side, master is the bus-driver side.
interface hd44780_i2c_target_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_out;
  logic       busy;
  logic [7:0] port;
  logic       backlight;
  logic       nibble_mode;
  logic       lcd_valid;
  logic       lcd_rs;
  logic [7:0] lcd_data;

  modport slave (
    input  scl_in, sda_in,
    output sda_out, busy, port, backlight, nibble_mode, lcd_valid, lcd_rs, lcd_data
  );

  modport master (
    output scl_in, sda_in,
    input  sda_out, busy, port, backlight, nibble_mode, lcd_valid, lcd_rs, lcd_data
  );
endinterface

// File: rtl/hd44780_i2c_target_core.sv
// i2c_target_core: I2C target byte engine.
// Synchronizes SCL/SDA, detects START/STOP, runs the target FSM and drives
// the open-drain sda_out. Received write bytes appear on rx_byte together
// with a one-cycle byte_valid on the 8th detected SCL rise.
//   clk, rst          : clock, async active-high reset
//   scl_in, sda_in    : raw bus lines
//   tx_byte           : byte returned on reads (HD44780_TARGET_READ_EN only)
//   sda_out, busy     : registered bus drive and addressed flag
//   rx_byte, byte_valid : received byte strobe
// Optional macro: HD44780_TARGET_READ_EN enables the read path.
module i2c_target_core
  import hd44780_pkg::*;
#(
  parameter logic [6:0] ADDR = DEFAULT_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
`ifdef HD44780_TARGET_READ_EN
  input  logic [7:0] tx_byte,
`endif
  output logic       sda_out,
  output logic       busy,
  output logic [7:0] rx_byte,
  output logic       byte_valid
);

  logic [1:0] scl_sync_r;
  logic [1:0] sda_sync_r;
  logic       scl_d_r;
  logic       sda_d_r;
  tgt_state_t state_r;
  logic [2:0] bit_cnt_r;
  logic [6:0] shift_r;
  logic       sda_out_r;
  logic       busy_r;
`ifdef HD44780_TARGET_READ_EN
  logic       rw_r;
  logic [7:0] tx_r;
`endif

  logic scl_s;
  logic sda_s;
  logic scl_rise_s;
  logic scl_fall_s;
  logic start_s;
  logic stop_s;

  assign scl_s      = scl_sync_r[1];
  assign sda_s      = sda_sync_r[1];
  assign scl_rise_s = scl_s & ~scl_d_r;
  assign scl_fall_s = ~scl_s & scl_d_r;
  // SCL must be high on both samples so a data change at an SCL edge is not mistaken for START/STOP
  assign start_s    = scl_s & scl_d_r & sda_d_r & ~sda_s;
  assign stop_s     = scl_s & scl_d_r & ~sda_d_r & sda_s;

  assign rx_byte    = {shift_r, sda_s};
  assign byte_valid = (state_r == ST_WRITE) & scl_rise_s & (bit_cnt_r == 3'd7);
  assign sda_out    = sda_out_r;
  assign busy       = busy_r;

  // Two-flop synchronizers plus one edge-detect register per line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_d_r    <= 1'b1;
      sda_d_r    <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_in};
      sda_sync_r <= {sda_sync_r[0], sda_in};
      scl_d_r    <= scl_sync_r[1];
      sda_d_r    <= sda_sync_r[1];
    end
  end

  // Target FSM: address/data shifting, ACK and read-data drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 7'd0;
      sda_out_r <= 1'b1;
      busy_r    <= 1'b0;
`ifdef HD44780_TARGET_READ_EN
      rw_r      <= 1'b0;
      tx_r      <= 8'hFF;
`endif
    end else if (stop_s) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      sda_out_r <= 1'b1;
      busy_r    <= 1'b0;
    end else if (start_s) begin
      state_r   <= ST_ADDR;
      bit_cnt_r <= 3'd0;
      sda_out_r <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_r   <= {shift_r[5:0], sda_s};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              // shift_r holds the 7 address bits, sda_s is R/W
              if ((shift_r == ADDR) && !sda_s) begin
                state_r <= ST_ADDR_ACK;
                busy_r  <= 1'b1;
`ifdef HD44780_TARGET_READ_EN
                rw_r    <= 1'b0;
              end else if (shift_r == ADDR) begin
                state_r <= ST_ADDR_ACK;
                busy_r  <= 1'b1;
                rw_r    <= 1'b1;
`endif
              end else begin
                state_r <= ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          // First fall asserts ACK, second fall releases it
          if (scl_fall_s) begin
            if (sda_out_r) begin
              sda_out_r <= 1'b0;
            end else begin
              bit_cnt_r <= 3'd0;
`ifdef HD44780_TARGET_READ_EN
              if (rw_r) begin
                // The release fall is also where the first read bit goes out
                state_r   <= ST_READ;
                sda_out_r <= tx_byte[7];
                tx_r      <= {tx_byte[6:0], 1'b1};
              end else begin
                state_r   <= ST_WRITE;
                sda_out_r <= 1'b1;
              end
`else
              state_r   <= ST_WRITE;
              sda_out_r <= 1'b1;
`endif
            end
          end
        end
        ST_WRITE: begin
          if (scl_rise_s) begin
            shift_r   <= {shift_r[5:0], sda_s};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_WRITE_ACK;
            end
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall_s) begin
            if (sda_out_r) begin
              sda_out_r <= 1'b0;
            end else begin
              sda_out_r <= 1'b1;
              bit_cnt_r <= 3'd0;
              state_r   <= ST_WRITE;
            end
          end
        end
`ifdef HD44780_TARGET_READ_EN
        ST_READ: begin
          if (scl_fall_s) begin
            sda_out_r <= tx_r[7];
            tx_r      <= {tx_r[6:0], 1'b1};
          end else if (scl_rise_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_READ_ACK;
            end
          end
        end
        ST_READ_ACK: begin
          // Release for the master's ACK bit, then sample it
          if (scl_fall_s) begin
            sda_out_r <= 1'b1;
          end else if (scl_rise_s) begin
            if (sda_s) begin
              state_r <= ST_IGNORE;
            end else begin
              state_r   <= ST_READ;
              tx_r      <= tx_byte;
              bit_cnt_r <= 3'd0;
            end
          end
        end
`endif
        ST_IDLE, ST_IGNORE: begin
          sda_out_r <= 1'b1;
        end
        default: begin
          state_r   <= ST_IDLE;
          sda_out_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/hd44780_i2c_target.sv
// hd44780_i2c_target: PCF8574 LCD-backpack emulator with HD44780 decode.
// Holds the expander port, detects E strobes and reassembles 8-bit and
// 4-bit HD44780 transfers into single-cycle lcd_valid events.
//   clk, rst : clock, async active-high reset
//   bus      : hd44780_i2c_target_if.slave (I2C lines, port, LCD events)
// Optional macro: HD44780_TARGET_READ_EN enables reads of the port.
module hd44780_i2c_target
  import hd44780_pkg::*;
#(
  parameter logic [6:0] ADDR = DEFAULT_ADDR
) (
  input  logic                     clk,
  input  logic                     rst,
  hd44780_i2c_target_if.slave      bus
);

  logic [7:0] rx_byte_s;
  logic       byte_valid_s;
  logic       sda_out_s;
  logic       busy_s;

  logic [7:0] port_r;
  logic       old_e_r;
  logic       upd_r;
  logic       nibble_mode_r;
  logic       phase_hi_r;
  logic [3:0] high_r;
  logic       lcd_valid_r;
  logic       lcd_rs_r;
  logic [7:0] lcd_data_r;

  logic [3:0] nib_s;
  logic       strobe_s;

  i2c_target_core #(.ADDR(ADDR)) u_core (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (bus.scl_in),
    .sda_in     (bus.sda_in),
`ifdef HD44780_TARGET_READ_EN
    // Undriven quasi-bidirectional pins read back their last written value
    .tx_byte    (port_r),
`endif
    .sda_out    (sda_out_s),
    .busy       (busy_s),
    .rx_byte    (rx_byte_s),
    .byte_valid (byte_valid_s)
  );

  assign nib_s    = port_r[PORT_D_LSB +: 4];
  assign strobe_s = upd_r & is_strobe(old_e_r, port_r);

  assign bus.sda_out     = sda_out_s;
  assign bus.busy        = busy_s;
  assign bus.port        = port_r;
  assign bus.backlight   = port_r[PORT_BL];
  assign bus.nibble_mode = nibble_mode_r;
  assign bus.lcd_valid   = lcd_valid_r;
  assign bus.lcd_rs      = lcd_rs_r;
  assign bus.lcd_data    = lcd_data_r;

  // Expander port register; remembers the previous E for strobe detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_r  <= 8'hFF;
      old_e_r <= 1'b1;
      upd_r   <= 1'b0;
    end else begin
      upd_r <= byte_valid_s;
      if (byte_valid_s) begin
        port_r  <= rx_byte_s;
        old_e_r <= port_r[PORT_E];
      end
    end
  end

  // HD44780 transfer reassembly and interface-width tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nibble_mode_r <= 1'b0;
      phase_hi_r    <= 1'b1;
      high_r        <= 4'h0;
      lcd_valid_r   <= 1'b0;
      lcd_rs_r      <= 1'b0;
      lcd_data_r    <= 8'h00;
    end else begin
      lcd_valid_r <= 1'b0;
      if (strobe_s) begin
        if (!nibble_mode_r) begin
          lcd_valid_r <= 1'b1;
          lcd_rs_r    <= port_r[PORT_RS];
          lcd_data_r  <= {nib_s, 4'h0};
          if (!port_r[PORT_RS] && (nib_s == FSET_DL4)) begin
            nibble_mode_r <= 1'b1;
            phase_hi_r    <= 1'b1;
          end
        end else if (phase_hi_r) begin
          high_r     <= nib_s;
          phase_hi_r <= 1'b0;
        end else begin
          lcd_valid_r <= 1'b1;
          lcd_rs_r    <= port_r[PORT_RS];
          lcd_data_r  <= {high_r, nib_s};
          phase_hi_r  <= 1'b1;
          if (!port_r[PORT_RS] && (high_r == FSET_DL8)) begin
            nibble_mode_r <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hd44780_i2c_target.sv
// tb_hd44780_i2c_target: directed bench for hd44780_i2c_target.
// Acts as the I2C master on an open-drain SDA wire and records every
// lcd_valid event for comparison against hand-computed values.
// Honors HD44780_TARGET_READ_EN for the read scenario.
module tb_hd44780_i2c_target;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic clk;
  logic rst;
  logic scl_m;
  logic sda_m;
  int   pass_cnt;
  int   total_cnt;
  logic [8:0] ev_q[$];

  hd44780_i2c_target_if bus ();

  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & bus.sda_out;

  hd44780_i2c_target #(.ADDR(7'h27)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event recorder, sampled on the inactive edge
  always @(negedge clk) begin
    if (bus.lcd_valid === 1'b1) ev_q.push_back({bus.lcd_rs, bus.lcd_data});
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    ack = bus.sda_in;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      d[i] = bus.sda_in;
      wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
    end
    send_bit(master_ack);
  endtask

  // One complete transaction: E-high then E-low with the given nibble
  task automatic write_pair(input logic [3:0] nib, input logic rs, output logic nak);
    logic a0, a1, a2;
    i2c_start();
    send_byte(8'h4E, a0);
    send_byte({nib, 4'b1100} | {7'd0, rs}, a1);
    send_byte({nib, 4'b1000} | {7'd0, rs}, a2);
    i2c_stop();
    nak = a0 | a1 | a2;
  endtask

  task automatic write_byte4(input logic [7:0] b, input logic rs, output logic nak);
    logic n0, n1;
    write_pair(b[7:4], rs, n0);
    write_pair(b[3:0], rs, n1);
    nak = n0 | n1;
  endtask

  task automatic test_reset();
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(5);
    total_cnt += 8;
    if (bus.sda_out !== 1'b1) $display("FAIL reset_sda_out got %b want 1", bus.sda_out); else pass_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
    if (bus.port !== 8'hFF) $display("FAIL reset_port got %h want ff", bus.port); else pass_cnt++;
    if (bus.backlight !== 1'b1) $display("FAIL reset_backlight got %b want 1", bus.backlight); else pass_cnt++;
    if (bus.nibble_mode !== 1'b0) $display("FAIL reset_nibble got %b want 0", bus.nibble_mode); else pass_cnt++;
    if (bus.lcd_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.lcd_valid); else pass_cnt++;
    if (bus.lcd_rs !== 1'b0) $display("FAIL reset_rs got %b want 0", bus.lcd_rs); else pass_cnt++;
    if (bus.lcd_data !== 8'h00) $display("FAIL reset_data got %h want 00", bus.lcd_data); else pass_cnt++;
    rst = 1'b0;
    wait_clk(5);
  endtask

  task automatic test_basic_write();
    logic a0, a1, a2;
    logic busy_mid;
    ev_q.delete();
    i2c_start();
    send_byte(8'h4E, a0);
    busy_mid = bus.busy;
    send_byte(8'h3C, a1);
    send_byte(8'h38, a2);
    i2c_stop();
    wait_clk(Q);
    total_cnt += 8;
    if (a0 !== 1'b0) $display("FAIL basic_addr_ack got %b want 0", a0); else pass_cnt++;
    if (a1 !== 1'b0) $display("FAIL basic_data1_ack got %b want 0", a1); else pass_cnt++;
    if (a2 !== 1'b0) $display("FAIL basic_data2_ack got %b want 0", a2); else pass_cnt++;
    if (busy_mid !== 1'b1) $display("FAIL basic_busy got %b want 1", busy_mid); else pass_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL basic_busy_after_stop got %b want 0", bus.busy); else pass_cnt++;
    if (bus.port !== 8'h38) $display("FAIL basic_port got %h want 38", bus.port); else pass_cnt++;
    if (bus.nibble_mode !== 1'b0) $display("FAIL basic_nibble got %b want 0", bus.nibble_mode); else pass_cnt++;
    if (ev_q.size() != 1) $display("FAIL basic_event_count got %0d want 1", ev_q.size());
    else if (ev_q[0] !== 9'h030) $display("FAIL basic_event got %h want 030", ev_q[0]);
    else pass_cnt++;
  endtask

  task automatic test_read();
    logic a0;
    logic [7:0] rd;
    i2c_start();
    send_byte(8'h4F, a0);
`ifdef HD44780_TARGET_READ_EN
    recv_byte(1'b1, rd);
    total_cnt += 2;
    if (a0 !== 1'b0) $display("FAIL read_addr_ack got %b want 0", a0); else pass_cnt++;
    if (rd !== 8'h38) $display("FAIL read_data got %h want 38", rd); else pass_cnt++;
`else
    rd = 8'h00;
    total_cnt += 1;
    if (a0 !== 1'b1) $display("FAIL read_addr_nack got %b want 1", a0); else pass_cnt++;
`endif
    i2c_stop();
    wait_clk(Q);
    total_cnt += 1;
    if (bus.port !== 8'h38) $display("FAIL read_port got %h want 38 (rd %h)", bus.port, rd); else pass_cnt++;
  endtask

  task automatic test_init();
    logic nak;
    logic any_nak;
    logic [8:0] exp_ev [8];
    exp_ev = '{9'h030, 9'h030, 9'h030, 9'h020, 9'h028, 9'h001, 9'h00C, 9'h006};
    ev_q.delete();
    any_nak = 1'b0;
    for (int i = 0; i < 3; i++) begin
      write_pair(4'h3, 1'b0, nak);
      any_nak |= nak;
    end
    total_cnt += 1;
    if (bus.nibble_mode !== 1'b0) $display("FAIL init_nibble_before got %b want 0", bus.nibble_mode); else pass_cnt++;
    write_pair(4'h2, 1'b0, nak);
    any_nak |= nak;
    total_cnt += 1;
    if (bus.nibble_mode !== 1'b1) $display("FAIL init_nibble_after got %b want 1", bus.nibble_mode); else pass_cnt++;
    write_byte4(8'h28, 1'b0, nak); any_nak |= nak;
    write_byte4(8'h01, 1'b0, nak); any_nak |= nak;
    write_byte4(8'h0C, 1'b0, nak); any_nak |= nak;
    write_byte4(8'h06, 1'b0, nak); any_nak |= nak;
    total_cnt += 3;
    if (any_nak !== 1'b0) $display("FAIL init_acks got nak %b want 0", any_nak); else pass_cnt++;
    if (bus.nibble_mode !== 1'b1) $display("FAIL init_nibble_end got %b want 1", bus.nibble_mode); else pass_cnt++;
    if (ev_q.size() != 8) $display("FAIL init_event_count got %0d want 8", ev_q.size()); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt += 1;
      if (i >= ev_q.size()) $display("FAIL init_event%0d got none want %h", i, exp_ev[i]);
      else if (ev_q[i] !== exp_ev[i]) $display("FAIL init_event%0d got %h want %h", i, ev_q[i], exp_ev[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_four_bit_data();
    logic a0, a1, a2, a3, a4;
    ev_q.delete();
    i2c_start();
    send_byte(8'h4E, a0);
    send_byte(8'h4D, a1);
    send_byte(8'h49, a2);
    send_byte(8'h1D, a3);
    send_byte(8'h19, a4);
    i2c_stop();
    wait_clk(Q);
    total_cnt += 4;
    if ((a0 | a1 | a2 | a3 | a4) !== 1'b0) $display("FAIL four_acks got %b%b%b%b%b want 00000", a0, a1, a2, a3, a4); else pass_cnt++;
    if (ev_q.size() != 1) $display("FAIL four_event_count got %0d want 1", ev_q.size());
    else if (ev_q[0] !== 9'h141) $display("FAIL four_event got %h want 141", ev_q[0]);
    else pass_cnt++;
    if (bus.backlight !== 1'b1) $display("FAIL four_backlight got %b want 1", bus.backlight); else pass_cnt++;
    if (bus.port !== 8'h19) $display("FAIL four_port got %h want 19", bus.port); else pass_cnt++;
  endtask

  task automatic test_exit_nibble();
    logic nak;
    ev_q.delete();
    write_byte4(8'h30, 1'b0, nak);
    total_cnt += 3;
    if (nak !== 1'b0) $display("FAIL exit_acks got nak %b want 0", nak); else pass_cnt++;
    if (bus.nibble_mode !== 1'b0) $display("FAIL exit_nibble got %b want 0", bus.nibble_mode); else pass_cnt++;
    if (ev_q.size() != 1) $display("FAIL exit_event_count got %0d want 1", ev_q.size());
    else if (ev_q[0] !== 9'h030) $display("FAIL exit_event got %h want 030", ev_q[0]);
    else pass_cnt++;
  endtask

  task automatic test_addr_nack();
    logic a0, a1;
    logic busy_mid;
    ev_q.delete();
    i2c_start();
    send_byte(8'h40, a0);
    send_byte(8'hFF, a1);
    busy_mid = bus.busy;
    i2c_stop();
    wait_clk(Q);
    total_cnt += 5;
    if (a0 !== 1'b1) $display("FAIL nack_addr got %b want 1", a0); else pass_cnt++;
    if (a1 !== 1'b1) $display("FAIL nack_data got %b want 1", a1); else pass_cnt++;
    if (busy_mid !== 1'b0) $display("FAIL nack_busy got %b want 0", busy_mid); else pass_cnt++;
    if (bus.port !== 8'h08) $display("FAIL nack_port got %h want 08", bus.port); else pass_cnt++;
    if (ev_q.size() != 0) $display("FAIL nack_events got %0d want 0", ev_q.size()); else pass_cnt++;
  endtask

  task automatic test_partial_stop();
    logic a0, a1;
    logic [7:0] pb;
    pb = 8'hA5;
    ev_q.delete();
    i2c_start();
    send_byte(8'h4E, a0);
    for (int i = 7; i >= 3; i--) send_bit(pb[i]);
    i2c_stop();
    wait_clk(Q);
    total_cnt += 3;
    if (a0 !== 1'b0) $display("FAIL partial_addr_ack got %b want 0", a0); else pass_cnt++;
    if (bus.port !== 8'h08) $display("FAIL partial_port got %h want 08", bus.port); else pass_cnt++;
    if (ev_q.size() != 0) $display("FAIL partial_events got %0d want 0", ev_q.size()); else pass_cnt++;
    i2c_start();
    send_byte(8'h4E, a1);
    i2c_stop();
    total_cnt += 1;
    if (a1 !== 1'b0) $display("FAIL partial_reacquire_ack got %b want 0", a1); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic nak, a0, a1;
    write_pair(4'h2, 1'b0, nak);
    total_cnt += 1;
    if ((nak !== 1'b0) || (bus.nibble_mode !== 1'b1))
      $display("FAIL midrst_setup got nak %b nibble %b want 0 1", nak, bus.nibble_mode);
    else pass_cnt++;
    i2c_start();
    send_byte(8'h4E, a0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rst = 1'b1;
    #1;
    total_cnt += 5;
    if (a0 !== 1'b0) $display("FAIL midrst_addr_ack got %b want 0", a0); else pass_cnt++;
    if (bus.port !== 8'hFF) $display("FAIL midrst_port got %h want ff", bus.port); else pass_cnt++;
    if (bus.nibble_mode !== 1'b0) $display("FAIL midrst_nibble got %b want 0", bus.nibble_mode); else pass_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", bus.busy); else pass_cnt++;
    if (bus.sda_out !== 1'b1) $display("FAIL midrst_sda_out got %b want 1", bus.sda_out); else pass_cnt++;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);
    i2c_stop();
    i2c_start();
    send_byte(8'h4E, a1);
    i2c_stop();
    total_cnt += 1;
    if (a1 !== 1'b0) $display("FAIL midrst_reacquire_ack got %b want 0", a1); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_basic_write();
    test_read();
    test_init();
    test_four_bit_data();
    test_exit_nibble();
    test_addr_nack();
    test_partial_stop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
